// File: rtl/alu_sched.sv
// Shared 4-op ALU scheduler: arbitrates two requesters, runs one op at a time, owns NZCV.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_sched #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_ctrl0,
    input  logic [1:0]       req_ctrl1,
    input  logic [1:0]       req_setflags,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       ctrl_q;
    logic             setflags_q;
    logic             owner_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic             last_grant_q;
`endif

    logic             grant_valid;
    logic             grant;

    always_comb begin
        grant_valid = |req_valid;
        grant       = 1'b0;
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
`ifdef ALU_SCHED_FIXED_PRIO_EN
            2'b11:   grant = 1'b0;
`else
            2'b11:   grant = ~last_grant_q;
`endif
            default: grant = 1'b0;
        endcase
    end

    assign req_ready = (state_q == StIdle && grant_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != StIdle);

    // One extra bit on the sum/difference carries C (carry out for ADD, borrow for SUB).
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    always_comb begin
        alu_sum = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (ctrl_q)
            2'b00: begin
                alu_sum = {1'b0, a_q} + {1'b0, b_q};
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b01: begin
                alu_sum = {1'b0, a_q} - {1'b0, b_q};
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b10:   alu_sum = {1'b0, a_q & b_q};
            2'b11:   alu_sum = {1'b0, a_q | b_q};
            default: alu_sum = '0;
        endcase
        alu_res   = alu_sum[WIDTH-1:0];
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= 2'b00;
            setflags_q   <= 1'b0;
            owner_q      <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= 4'b0000;
            flags        <= 4'b0000;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        a_q        <= grant ? req_a1 : req_a0;
                        b_q        <= grant ? req_b1 : req_b0;
                        ctrl_q     <= grant ? req_ctrl1 : req_ctrl0;
                        setflags_q <= req_setflags[grant];
                        owner_q    <= grant;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                        last_grant_q <= grant;
`endif
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= alu_res;
                    rsp_flags  <= alu_flags;
                    if (setflags_q) begin
                        flags <= alu_flags;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: accepts push expected responses, a monitor pops and compares.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ctrl0, req_ctrl1;
    logic [1:0]  req_setflags;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags;
    logic        busy;

    alu_sched #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .req_ctrl0    (req_ctrl0),
        .req_ctrl1    (req_ctrl1),
        .req_setflags (req_setflags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .flags        (flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  arch;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic        grant_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          acc_count = 0;
    int          last_acc  = -1;
    bit          spacing_on = 1'b0;
    logic [1:0]  prev_rv = 2'b00;
    logic [31:0] pend_res[2];
    logic [3:0]  pend_flg[2];
    logic [3:0]  pend_arch[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Accept watcher: a nonzero req_ready at the falling edge means a handshake at the next rise.
    always @(negedge clk) begin
        if (!reset && req_ready != 2'b00) begin
            exp_t e;
            logic p;
            logic g;
            p = req_ready[1];
            chk("req_ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
            if (grant_q.size() > 0) begin
                g = grant_q.pop_front();
                chk("grant_order", {63'd0, p}, {63'd0, g});
            end
            if (spacing_on && last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, 64'd3);
            last_acc = cyc + 1;
            e.port = p;
            e.res  = pend_res[p];
            e.flg  = pend_flg[p];
            e.arch = pend_arch[p];
            e.acc  = cyc + 1;
            sb.push_back(e);
            acc_count++;
        end
    end

    // Response monitor: compare on the cycle rsp_valid rises.
    always @(negedge clk) begin
        if (reset) begin
            prev_rv = 2'b00;
        end else begin
            if (rsp_valid != 2'b00 && prev_rv == 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_valid_port", {62'd0, rsp_valid}, e.port ? 64'd2 : 64'd1);
                    chk("rsp_latency", cyc, e.acc + 1);
                    chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
                    chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flg});
                    chk("arch_flags", {60'd0, flags}, {60'd0, e.arch});
                    chk("busy_in_resp", {63'd0, busy}, 64'd1);
                end
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] ctrl, input logic sf, input logic [31:0] res,
                           input logic [3:0] flg, input logic [3:0] arch);
        if (p == 0) begin
            req_a0 = a; req_b0 = b; req_ctrl0 = ctrl;
        end else begin
            req_a1 = a; req_b1 = b; req_ctrl1 = ctrl;
        end
        req_setflags[p] = sf;
        pend_res[p]  = res;
        pend_flg[p]  = flg;
        pend_arch[p] = arch;
        req_valid[p] = 1'b1;
    endtask

    task automatic wait_accept(input int p);
        int  start;
        bit  got;
        start = acc_count;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (acc_count != start) got = 1'b1;
        end
        chk("accept_seen", {63'd0, got}, 64'd1);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && rsp_valid == 2'b00) done = 1'b1;
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_rsp(input int p);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[p]) got = 1'b1;
        end
        chk("rsp_seen", {63'd0, got}, 64'd1);
    endtask

    initial begin
        int start;
        reset = 1'b1;
        req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_ctrl0 = 2'b00; req_ctrl1 = 2'b00;
        req_setflags = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
        chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
        chk("reset_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        chk("reset_flags", {60'd0, flags}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD overflow into sign bit, flags written
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 32'h8000_0000, 4'b1001, 4'b1001);
        wait_accept(0);
        wait_empty("add_done");

        // SUB equal operands, flags untouched
        set_req(1, 32'h0000_0005, 32'h0000_0005, 2'b01, 1'b0, 32'h0, 4'b0100, 4'b1001);
        wait_accept(1);
        wait_empty("sub_done");
        chk("flags_kept", {60'd0, flags}, 64'h9);

        // Both ports contending for four ops
        set_req(0, 32'h1, 32'h2, 2'b00, 1'b0, 32'h3, 4'b0000, 4'b1001);
        set_req(1, 32'h10, 32'h01, 2'b11, 1'b0, 32'h11, 4'b0000, 4'b1001);
`ifdef ALU_SCHED_FIXED_PRIO_EN
        grant_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        last_acc   = -1;
        spacing_on = 1'b1;
        start = acc_count;
        for (int i = 0; i < 40 && acc_count < start + 4; i++) begin
            @(posedge clk); #1;
        end
        chk("rr_four_accepts", acc_count - start, 64'd4);
        req_valid  = 2'b00;
        spacing_on = 1'b0;
        wait_empty("rr_done");
        chk("rr_grants_used", grant_q.size(), 64'd0);

        // AND with stalled response; port 1 queued behind it must be held off
        rsp_ready = 2'b00;
        set_req(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 1'b0, 32'h0, 4'b0100, 4'b1001);
        wait_accept(0);
        set_req(1, 32'h0000_0000, 32'h0000_0001, 2'b01, 1'b1, 32'hFFFF_FFFF, 4'b1010, 4'b1010);
        wait_rsp(0);
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", {62'd0, rsp_valid}, 64'd1);
            chk("stall_result", {32'd0, rsp_result}, 64'd0);
            chk("stall_flags", {60'd0, rsp_flags}, 64'h4);
            chk("stall_req_ready", {62'd0, req_ready}, 64'd0);
        end
        rsp_ready = 2'b11;
        wait_accept(1);
        wait_empty("sub_borrow_done");
        chk("flags_after_borrow", {60'd0, flags}, 64'hA);

        // Reset while an op sits in RESP
        rsp_ready = 2'b00;
        set_req(0, 32'h0000_0000, 32'h0000_0001, 2'b01, 1'b1, 32'hFFFF_FFFF, 4'b1010, 4'b1010);
        wait_accept(0);
        wait_rsp(0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        reset = 1'b0;
        rsp_ready = 2'b11;
        sb.delete();

        // Normal service after reset: ADD with carry out to zero
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 32'h0, 4'b0110, 4'b0110);
        wait_accept(1);
        wait_empty("post_reset_done");
        chk("flags_post_reset", {60'd0, flags}, 64'h6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
